// File: rtl/qed_trace_capture.sv
// Multi-channel QED trace recorder: per-channel circular buffers frozen by a fault trigger.
// Optional macro QED_TRACE_TSTAMP_EN adds a per-entry timestamp from the cycle counter.
module qed_trace_capture #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned POST_TRIG = 0,
  parameter int unsigned TS_W      = 16,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned CW       = AW + 1,
  localparam int unsigned ChW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                 fault,
  input  logic                 arm,
  input  logic                 rd_en,
  input  logic [ChW-1:0]       rd_ch,
  input  logic [AW-1:0]        rd_idx,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_data,
  output logic [TS_W-1:0]      rd_tstamp,
  output logic                 rd_err,
  output logic [1:0]           state,
  output logic [NUM_CH*CW-1:0] fill_count,
  output logic [31:0]          fault_cycle
);

  localparam logic [1:0] StCapture = 2'd0;
  localparam logic [1:0] StPost    = 2'd1;
  localparam logic [1:0] StFrozen  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     post_cnt_q, post_cnt_d;
  logic [31:0]       cyc_cnt_q, cyc_cnt_d;
  logic [31:0]       fault_cycle_q, fault_cycle_d;
  logic [AW-1:0]     wr_ptr_q [NUM_CH];
  logic [AW-1:0]     wr_ptr_d [NUM_CH];
  logic [CW-1:0]     fill_q [NUM_CH];
  logic [CW-1:0]     fill_d [NUM_CH];
  logic [NUM_CH-1:0] wr_en;

  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_err_q, rd_err_d;

  logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];

  logic              capturing;
  logic              rd_ch_ok;
  logic              rd_hit;
  logic [ChW-1:0]    rd_sel;
  logic [CW-1:0]     rd_fill;
  logic [AW-1:0]     rd_addr;

  assign capturing = (state_q != StFrozen);

  always_comb begin
    state_d       = state_q;
    post_cnt_d    = post_cnt_q;
    cyc_cnt_d     = cyc_cnt_q;
    fault_cycle_d = fault_cycle_q;
    wr_ptr_d      = wr_ptr_q;
    fill_d        = fill_q;
    wr_en         = '0;

    // Counter keeps running through the post window so timestamps stay distinct.
    if (capturing && (cyc_cnt_q != '1)) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
    end

    for (int c = 0; c < NUM_CH; c++) begin
      wr_en[c] = capturing && in_valid[c];
      if (wr_en[c]) begin
        wr_ptr_d[c] = wr_ptr_q[c] + AW'(1);
        if (fill_q[c] != CW'(DEPTH)) begin
          fill_d[c] = fill_q[c] + CW'(1);
        end
      end
    end

    case (state_q)
      StCapture: begin
        if (fault) begin
          fault_cycle_d = cyc_cnt_q;
          if (POST_TRIG == 0) begin
            state_d = StFrozen;
          end else begin
            state_d    = StPost;
            post_cnt_d = CW'(POST_TRIG);
          end
        end
      end
      StPost: begin
        post_cnt_d = post_cnt_q - CW'(1);
        if (post_cnt_q == CW'(1)) begin
          state_d = StFrozen;
        end
      end
      StFrozen: begin
        if (arm) begin
          state_d       = StCapture;
          cyc_cnt_d     = '0;
          fault_cycle_d = '0;
          for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = '0;
            fill_d[c]   = '0;
          end
        end
      end
      default: state_d = StCapture;
    endcase
  end

  // Read path: oldest valid entry sits fill entries behind the write pointer.
  always_comb begin
    rd_ch_ok   = (32'(rd_ch) < NUM_CH);
    rd_sel     = rd_ch_ok ? rd_ch : '0;
    rd_fill    = fill_q[rd_sel];
    rd_hit     = rd_en && (state_q == StFrozen) && rd_ch_ok && ({1'b0, rd_idx} < rd_fill);
    rd_addr    = wr_ptr_q[rd_sel] - rd_fill[AW-1:0] + rd_idx;
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    if (rd_en) begin
      rd_err_d  = !rd_hit;
      rd_data_d = rd_hit ? mem_q[rd_sel][rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StCapture;
      post_cnt_q    <= '0;
      cyc_cnt_q     <= '0;
      fault_cycle_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_err_q      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        fill_q[c]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      post_cnt_q    <= post_cnt_d;
      cyc_cnt_q     <= cyc_cnt_d;
      fault_cycle_q <= fault_cycle_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      rd_err_q      <= rd_err_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_q        <= fill_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) begin
        mem_q[c][wr_ptr_q[c]] <= in_data[c*DATA_W +: DATA_W];
      end
    end
  end

`ifdef QED_TRACE_TSTAMP_EN
  logic [TS_W-1:0] ts_mem_q [NUM_CH][DEPTH];
  logic [TS_W-1:0] rd_ts_q, rd_ts_d;

  always_comb begin
    rd_ts_d = rd_ts_q;
    if (rd_en) begin
      rd_ts_d = rd_hit ? ts_mem_q[rd_sel][rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ts_q <= '0;
    end else begin
      rd_ts_q <= rd_ts_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) begin
        ts_mem_q[c][wr_ptr_q[c]] <= TS_W'(cyc_cnt_q);
      end
    end
  end

  assign rd_tstamp = rd_ts_q;
`else
  assign rd_tstamp = '0;
`endif

  always_comb begin
    fill_count = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fill_count[c*CW +: CW] = fill_q[c];
    end
  end

  assign state       = state_q;
  assign fault_cycle = fault_cycle_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_qed_trace_capture.sv
// Scoreboard bench for qed_trace_capture: instance 0 has POST_TRIG=0, instance 1 has POST_TRIG=3.
module tb_qed_trace_capture;
  localparam int unsigned NCH = 2;
  localparam int unsigned DEP = 16;
  localparam int unsigned DW  = 64;
  localparam int unsigned TSW = 16;
  localparam int unsigned CW  = 5;
`ifdef QED_TRACE_TSTAMP_EN
  localparam bit TsEn = 1'b1;
`else
  localparam bit TsEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    in_valid [2];
  logic [NCH*DW-1:0] in_data [2];
  logic              fault [2];
  logic              arm [2];
  logic              rd_en [2];
  logic              rd_ch [2];
  logic [3:0]        rd_idx [2];
  logic              rd_valid [2];
  logic [DW-1:0]     rd_data [2];
  logic [TSW-1:0]    rd_tstamp [2];
  logic              rd_err [2];
  logic [1:0]        state [2];
  logic [NCH*CW-1:0] fill_count [2];
  logic [31:0]       fault_cycle [2];

  qed_trace_capture #(
    .NUM_CH(NCH), .DEPTH(DEP), .DATA_W(DW), .POST_TRIG(0), .TS_W(TSW)
  ) u_dut0 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .fault(fault[0]), .arm(arm[0]), .rd_en(rd_en[0]), .rd_ch(rd_ch[0]), .rd_idx(rd_idx[0]),
    .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_tstamp(rd_tstamp[0]), .rd_err(rd_err[0]),
    .state(state[0]), .fill_count(fill_count[0]), .fault_cycle(fault_cycle[0])
  );

  qed_trace_capture #(
    .NUM_CH(NCH), .DEPTH(DEP), .DATA_W(DW), .POST_TRIG(3), .TS_W(TSW)
  ) u_dut1 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .fault(fault[1]), .arm(arm[1]), .rd_en(rd_en[1]), .rd_ch(rd_ch[1]), .rd_idx(rd_idx[1]),
    .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_tstamp(rd_tstamp[1]), .rd_err(rd_err[1]),
    .state(state[1]), .fill_count(fill_count[1]), .fault_cycle(fault_cycle[1])
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic           err;
    logic [TSW-1:0] ts;
    bit             chk_ts;
    string          name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read; caller deasserts rd_en after a burst.
  task automatic rd(input int d, input logic ch, input int idx, input logic [63:0] data,
                    input logic err, input logic [15:0] ts, input bit chk_ts, input string name);
    exp_t e;
    rd_en[d]  = 1'b1;
    rd_ch[d]  = ch;
    rd_idx[d] = 4'(idx);
    e.data = data;
    e.err = err;
    e.ts = ts;
    e.chk_ts = chk_ts;
    e.name = name;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    tick();
  endtask

  // Monitor: pops one expectation per presented response.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rd_valid[d] === 1'b1) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_checks++;
          $display("FAIL rd_unexpected_dut%0d: got rd_valid 1 expected no response", d);
        end else begin
          if (d == 0) e = q0.pop_front();
          else e = q1.pop_front();
          check({e.name, "_data"}, rd_data[d], e.data);
          check({e.name, "_err"}, 64'(rd_err[d]), 64'(e.err));
          if (e.chk_ts) check({e.name, "_ts"}, 64'(rd_tstamp[d]), 64'(e.ts));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = '0; in_data[d] = '0; fault[d] = 1'b0; arm[d] = 1'b0;
      rd_en[d] = 1'b0; rd_ch[d] = 1'b0; rd_idx[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_state0", 64'(state[0]), 0);
    check("rst_state1", 64'(state[1]), 0);
    check("rst_fill0", 64'(fill_count[0]), 0);
    check("rst_fc0", 64'(fault_cycle[0]), 0);
    check("rst_rdv0", 64'(rd_valid[0]), 0);
    check("rst_rddata0", rd_data[0], 0);
    rst_n = 1'b1;

    // Five writes, fault on the fifth; counter value at that cycle is 4.
    for (int i = 1; i <= 5; i++) begin
      in_valid[0] = 2'b11;
      in_data[0]  = {64'(i + 100), 64'(i)};
      fault[0]    = (i == 5);
      tick();
    end
    in_valid[0] = '0;
    fault[0] = 1'b0;
    check("t1_state", 64'(state[0]), 2);
    check("t1_fill", 64'(fill_count[0]), {5'd5, 5'd5});
    check("t1_fault_cycle", 64'(fault_cycle[0]), 4);
    for (int i = 0; i < 5; i++) rd(0, 1'b0, i, 64'(i + 1), 1'b0, TsEn ? 16'(i) : 16'd0, 1'b1, "t1_ch0");
    rd(0, 1'b0, 7, 64'd0, 1'b1, 16'd0, 1'b1, "t1_idx_oob");
    for (int i = 0; i < 5; i++) rd(0, 1'b1, i, 64'(i + 101), 1'b0, TsEn ? 16'(i) : 16'd0, 1'b1, "t1_ch1");
    rd_en[0] = 1'b0;
    tick();
    check("hold_rdv", 64'(rd_valid[0]), 0);
    check("hold_data", rd_data[0], 105);
    check("hold_err", 64'(rd_err[0]), 0);

    // Arm wins over fault in FROZEN.
    arm[0] = 1'b1;
    fault[0] = 1'b1;
    tick();
    arm[0] = 1'b0;
    fault[0] = 1'b0;
    check("arm_state", 64'(state[0]), 0);
    check("arm_fill", 64'(fill_count[0]), 0);
    check("arm_fc", 64'(fault_cycle[0]), 0);
    rd(0, 1'b0, 0, 64'd0, 1'b1, 16'd0, 1'b1, "capture_rd");
    rd_en[0] = 1'b0;

    // Twenty writes into sixteen entries; oldest surviving value is 4.
    for (int v = 0; v < 20; v++) begin
      in_valid[0] = 2'b11;
      in_data[0]  = {64'(v + 200), 64'(v)};
      fault[0]    = (v == 19);
      tick();
    end
    check("wrap_state", 64'(state[0]), 2);
    check("wrap_fill", 64'(fill_count[0]), {5'd16, 5'd16});
    check("wrap_fc", 64'(fault_cycle[0]), 20);
    in_data[0] = '1;
    fault[0]   = 1'b1;
    tick();
    in_valid[0] = '0;
    fault[0] = 1'b0;
    check("frozen_fill", 64'(fill_count[0]), {5'd16, 5'd16});
    check("frozen_fc", 64'(fault_cycle[0]), 20);
    rd(0, 1'b0, 0, 64'd4, 1'b0, 16'd0, !TsEn, "wrap_ch0_old");
    rd(0, 1'b0, 15, 64'd19, 1'b0, 16'd0, !TsEn, "wrap_ch0_new");
    rd(0, 1'b1, 0, 64'd204, 1'b0, 16'd0, !TsEn, "wrap_ch1_old");
    rd(0, 1'b1, 15, 64'd219, 1'b0, 16'd0, !TsEn, "wrap_ch1_new");
    rd_en[0] = 1'b0;

    // Post-trigger window of three cycles on instance 1.
    for (int v = 0; v < 15; v++) begin
      in_valid[1] = 2'b11;
      in_data[1]  = {64'(v + 50), 64'(v)};
      fault[1]    = (v == 10);
      tick();
      if (v == 10) check("post_state_a", 64'(state[1]), 1);
      if (v == 12) check("post_state_b", 64'(state[1]), 1);
      if (v == 13) check("post_state_c", 64'(state[1]), 2);
    end
    in_valid[1] = '0;
    fault[1] = 1'b0;
    check("post_fill", 64'(fill_count[1]), {5'd14, 5'd14});
    rd(1, 1'b0, 0, 64'd0, 1'b0, 16'd0, !TsEn, "post_ch0_old");
    rd(1, 1'b0, 13, 64'd13, 1'b0, 16'd0, !TsEn, "post_ch0_last");
    rd(1, 1'b1, 13, 64'd63, 1'b0, 16'd0, !TsEn, "post_ch1_last");
    rd(1, 1'b0, 14, 64'd0, 1'b1, 16'd0, 1'b1, "post_idx_oob");
    rd_en[1] = 1'b0;
    tick();

    // Async reset mid-POST with a read response in flight on instance 0.
    arm[1] = 1'b1;
    tick();
    arm[1] = 1'b0;
    check("rearm_state", 64'(state[1]), 0);
    for (int v = 0; v < 3; v++) begin
      in_valid[1] = 2'b11;
      in_data[1]  = {64'(v + 70), 64'(v + 30)};
      fault[1]    = (v == 2);
      tick();
    end
    in_valid[1] = '0;
    fault[1] = 1'b0;
    check("mid_post_state", 64'(state[1]), 1);
    check("mid_post_fill", 64'(fill_count[1]), {5'd3, 5'd3});
    rd_en[0] = 1'b1;
    rd_ch[0] = 1'b0;
    rd_idx[0] = 4'd0;
    tick();
    rd_en[0] = 1'b0;
    check("inflight_rdv", 64'(rd_valid[0]), 1);
    check("inflight_data", rd_data[0], 4);
    check("inflight_post", 64'(state[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state1", 64'(state[1]), 0);
    check("arst_fill1", 64'(fill_count[1]), 0);
    check("arst_fc1", 64'(fault_cycle[1]), 0);
    check("arst_state0", 64'(state[0]), 0);
    check("arst_fc0", 64'(fault_cycle[0]), 0);
    check("arst_rdv0", 64'(rd_valid[0]), 0);
    check("arst_rddata0", rd_data[0], 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("sb_drain_dut0", 64'(q0.size()), 0);
    check("sb_drain_dut1", 64'(q1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
